// File: rtl/xor_txn_initiator_if.sv
// Handshake bundle between the XOR transaction initiator and its neighbours.
// The command port faces the sequencer; the A, B and Y channels face the
// XOR stream block. The master modport is the initiator's view.
interface xor_txn_initiator_if;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_a;
  logic cmd_b;
  logic a_data;
  logic a_en;
  logic a_rdy;
  logic b_data;
  logic b_en;
  logic b_rdy;
  logic y_data;
  logic y_en;
  logic y_rdy;
  logic y_stall;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, a_rdy, b_rdy, y_data, y_en, y_stall,
    output cmd_ready, a_data, a_en, b_data, b_en, y_rdy
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, a_rdy, b_rdy, y_data, y_en, y_stall,
    input  cmd_ready, a_data, a_en, b_data, b_en, y_rdy
  );
endinterface

// File: rtl/xor_txn_initiator.sv
// Initiator for the 1-bit XOR stream block: drives operand pairs onto the
// A and B channels, queues a^b, and checks returned Y results in order.
module xor_txn_initiator #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  xor_txn_initiator_if.master    bus,
  output logic [CNT_W-1:0]       match_cnt,
  output logic [CNT_W-1:0]       err_cnt,
  output logic                   err_pulse,
  output logic                   unexpected,
  output logic                   timeout,
  output logic                   idle
);

  localparam int AW   = $clog2(DEPTH);
  localparam int FCW  = AW + 1;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [FCW-1:0]  FIFO_FULL = FCW'(DEPTH);
  localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(TIMEOUT);

  typedef enum logic {CH_IDLE, CH_DRIVE} ch_state_t;

  ch_state_t        a_state, a_state_nxt;
  ch_state_t        b_state, b_state_nxt;
  logic             a_data_q, b_data_q;
  logic             fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [FCW-1:0]   fifo_count;
  logic [WD_W-1:0]  wd_cnt, wd_nxt;
  logic             push, pop, head, result_ok;

  assign bus.a_en   = (a_state == CH_DRIVE);
  assign bus.b_en   = (b_state == CH_DRIVE);
  assign bus.a_data = a_data_q;
  assign bus.b_data = b_data_q;

  assign bus.cmd_ready = !bus.a_en && !bus.b_en && (fifo_count < FIFO_FULL);
  assign bus.y_rdy     = !bus.y_stall && (fifo_count != '0);
  assign idle          = !bus.a_en && !bus.b_en && (fifo_count == '0);

  assign push      = bus.cmd_valid && bus.cmd_ready;
  assign pop       = bus.y_en && bus.y_rdy;
  assign head      = fifo_mem[rd_ptr];
  assign result_ok = (bus.y_data == head);

  // Channel state registers; reset drops any pending A/B drive.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_state <= CH_IDLE;
      b_state <= CH_IDLE;
    end else begin
      a_state <= a_state_nxt;
      b_state <= b_state_nxt;
    end
  end

  // Each channel drives from command accept until its own en&&rdy handshake.
  always_comb begin
    a_state_nxt = a_state;
    b_state_nxt = b_state;
    case (a_state)
      CH_IDLE:  if (push) a_state_nxt = CH_DRIVE;
      CH_DRIVE: if (bus.a_rdy) a_state_nxt = CH_IDLE;
      default:  a_state_nxt = CH_IDLE;
    endcase
    case (b_state)
      CH_IDLE:  if (push) b_state_nxt = CH_DRIVE;
      CH_DRIVE: if (bus.b_rdy) b_state_nxt = CH_IDLE;
      default:  b_state_nxt = CH_IDLE;
    endcase
  end

  // Operand registers load only on accept, so data stays stable while driving.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_data_q <= 1'b0;
      b_data_q <= 1'b0;
    end else if (push) begin
      a_data_q <= bus.cmd_a;
      b_data_q <= bus.cmd_b;
    end
  end

  // Expected-value storage; contents are only meaningful below fifo_count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.cmd_a ^ bus.cmd_b;
  end

  // FIFO pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCW'(1);
        2'b01:   fifo_count <= fifo_count - FCW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Watchdog counts stalled cycles with results outstanding, saturating.
  always_comb begin
    wd_nxt = wd_cnt;
    if (fifo_count == '0 || pop) wd_nxt = '0;
    else if (wd_cnt != WD_LIMIT)  wd_nxt = wd_cnt + WD_W'(1);
  end

  // Result scoreboard, sticky flags and watchdog; clear beats any update.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      match_cnt  <= '0;
      err_cnt    <= '0;
      err_pulse  <= 1'b0;
      unexpected <= 1'b0;
      timeout    <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      wd_cnt    <= wd_nxt;
      err_pulse <= pop && !result_ok;
      if (clear) begin
        match_cnt  <= '0;
        err_cnt    <= '0;
        unexpected <= 1'b0;
        timeout    <= 1'b0;
      end else begin
        if (pop && result_ok && match_cnt != '1)  match_cnt <= match_cnt + CNT_W'(1);
        if (pop && !result_ok && err_cnt != '1)   err_cnt   <= err_cnt + CNT_W'(1);
        if (bus.y_en && fifo_count == '0)         unexpected <= 1'b1;
        if (wd_nxt == WD_LIMIT)                   timeout    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xor_txn_initiator.sv
// Directed bench for xor_txn_initiator with small parameters so counter
// saturation and the watchdog are reachable in a few cycles.
module tb_xor_txn_initiator;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic [1:0] match_cnt;
  logic [1:0] err_cnt;
  logic       err_pulse;
  logic       unexpected;
  logic       timeout;
  logic       idle;
  int         compared;
  int         mismatched;

  xor_txn_initiator_if bus();

  xor_txn_initiator #(.DEPTH(4), .CNT_W(2), .TIMEOUT(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .bus        (bus),
    .match_cnt  (match_cnt),
    .err_cnt    (err_cnt),
    .err_pulse  (err_pulse),
    .unexpected (unexpected),
    .timeout    (timeout),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle away from the edge.
  task tick();
    @(posedge clk);
    #2;
  endtask

  // Drive all handshake inputs in one call.
  task applyStimulus(input logic cv, input logic ca, input logic cb,
                     input logic ar, input logic br, input logic ye,
                     input logic yd, input logic ys);
    bus.cmd_valid = cv;
    bus.cmd_a     = ca;
    bus.cmd_b     = cb;
    bus.a_rdy     = ar;
    bus.b_rdy     = br;
    bus.y_en      = ye;
    bus.y_data    = yd;
    bus.y_stall   = ys;
  endtask

  // One comparison against a hand-computed value.
  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  logic [3:0] vec_a;
  logic [3:0] vec_b;

  initial begin
    compared   = 0;
    mismatched = 0;
    vec_a      = 4'b1100;
    vec_b      = 4'b1010;
    reset_n    = 1'b0;
    clear      = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_a_en", 32'(bus.a_en), 0);
    checkOutput("rst_b_en", 32'(bus.b_en), 0);
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    checkOutput("rst_idle", 32'(idle), 1);
    checkOutput("rst_y_rdy", 32'(bus.y_rdy), 0);
    checkOutput("rst_match", 32'(match_cnt), 0);
    reset_n = 1'b1;

    $display("[TB] basic pair");
    applyStimulus(1, 1, 0, 1, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    checkOutput("basic_a_en", 32'(bus.a_en), 1);
    checkOutput("basic_b_en", 32'(bus.b_en), 1);
    checkOutput("basic_a_data", 32'(bus.a_data), 1);
    checkOutput("basic_b_data", 32'(bus.b_data), 0);
    checkOutput("basic_cmd_ready", 32'(bus.cmd_ready), 0);
    checkOutput("basic_y_rdy", 32'(bus.y_rdy), 1);
    tick();
    checkOutput("basic_a_en_drop", 32'(bus.a_en), 0);
    checkOutput("basic_b_en_drop", 32'(bus.b_en), 0);
    applyStimulus(0, 0, 0, 1, 1, 1, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    checkOutput("basic_match", 32'(match_cnt), 1);
    checkOutput("basic_err", 32'(err_cnt), 0);
    checkOutput("basic_err_pulse", 32'(err_pulse), 0);
    checkOutput("basic_idle", 32'(idle), 1);

    $display("[TB] skewed readiness");
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("skew_b_en_1", 32'(bus.b_en), 1);
    tick();
    checkOutput("skew_a_en_drop", 32'(bus.a_en), 0);
    checkOutput("skew_b_en_2", 32'(bus.b_en), 1);
    checkOutput("skew_cmd_ready_2", 32'(bus.cmd_ready), 0);
    tick();
    checkOutput("skew_b_en_3", 32'(bus.b_en), 1);
    tick();
    checkOutput("skew_b_en_4", 32'(bus.b_en), 1);
    checkOutput("skew_b_data", 32'(bus.b_data), 1);
    checkOutput("skew_cmd_ready_4", 32'(bus.cmd_ready), 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    tick();
    checkOutput("skew_b_en_drop", 32'(bus.b_en), 0);
    checkOutput("skew_cmd_ready_after", 32'(bus.cmd_ready), 1);
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    checkOutput("skew_match", 32'(match_cnt), 2);
    checkOutput("skew_err", 32'(err_cnt), 0);

    $display("[TB] mismatch and saturation");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, k[0], 0, 1, 1, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 1, 1, 1, ~k[0], 0);
      tick();
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
      checkOutput("mis_err_pulse_on", 32'(err_pulse), 1);
      checkOutput("mis_err_cnt", 32'(err_cnt), (k < 3) ? k + 1 : 3);
      tick();
      checkOutput("mis_err_pulse_off", 32'(err_pulse), 0);
    end
    checkOutput("mis_match_kept", 32'(match_cnt), 2);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clear_match", 32'(match_cnt), 0);
    checkOutput("clear_err", 32'(err_cnt), 0);

    $display("[TB] backpressure and full FIFO");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, vec_a[3-k], vec_b[3-k], 1, 1, 0, 0, 1);
      tick();
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 1);
      tick();
    end
    checkOutput("full_cmd_ready", 32'(bus.cmd_ready), 0);
    checkOutput("full_y_rdy", 32'(bus.y_rdy), 0);
    checkOutput("full_idle", 32'(idle), 0);
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 0);
    #1;
    checkOutput("release_y_rdy", 32'(bus.y_rdy), 1);
    tick();
    checkOutput("pop1_cmd_ready", 32'(bus.cmd_ready), 1);
    applyStimulus(0, 0, 0, 1, 1, 1, 1, 0);
    tick();
    tick();
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 0);
    checkOutput("pop3_match", 32'(match_cnt), 3);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    checkOutput("drain_match_sat", 32'(match_cnt), 3);
    checkOutput("drain_err", 32'(err_cnt), 0);
    checkOutput("drain_idle", 32'(idle), 1);
    checkOutput("drain_y_rdy", 32'(bus.y_rdy), 0);
    checkOutput("drain_timeout", 32'(timeout), 0);

    $display("[TB] watchdog");
    applyStimulus(1, 1, 0, 1, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    repeat (7) tick();
    checkOutput("wd_before", 32'(timeout), 0);
    tick();
    checkOutput("wd_set", 32'(timeout), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("wd_cleared", 32'(timeout), 0);
    applyStimulus(0, 0, 0, 1, 1, 1, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    checkOutput("wd_pop_match", 32'(match_cnt), 1);
    checkOutput("wd_after_pop", 32'(timeout), 0);

    $display("[TB] unexpected result");
    applyStimulus(0, 0, 0, 1, 1, 1, 1, 0);
    #1;
    checkOutput("unexp_y_rdy", 32'(bus.y_rdy), 0);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    checkOutput("unexp_set", 32'(unexpected), 1);
    checkOutput("unexp_no_count", 32'(match_cnt), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("unexp_cleared", 32'(unexpected), 0);

    $display("[TB] clear coinciding with transfer");
    applyStimulus(1, 0, 1, 1, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 1, 1, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    checkOutput("clr_xfer_match", 32'(match_cnt), 0);
    checkOutput("clr_xfer_idle", 32'(idle), 1);

    $display("[TB] reset mid-flight");
    applyStimulus(1, 1, 1, 1, 1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mid_a_en", 32'(bus.a_en), 1);
    checkOutput("mid_idle", 32'(idle), 0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkOutput("mid_rst_a_en", 32'(bus.a_en), 0);
    checkOutput("mid_rst_b_en", 32'(bus.b_en), 0);
    checkOutput("mid_rst_b_data", 32'(bus.b_data), 0);
    checkOutput("mid_rst_cmd_ready", 32'(bus.cmd_ready), 1);
    checkOutput("mid_rst_idle", 32'(idle), 1);
    checkOutput("mid_rst_y_rdy", 32'(bus.y_rdy), 0);
    checkOutput("mid_rst_timeout", 32'(timeout), 0);
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    checkOutput("mid_flushed_unexp", 32'(unexpected), 1);
    checkOutput("mid_flushed_match", 32'(match_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
